// File: rtl/booth_pkg.sv
// Shared definitions for the sequential radix-2 Booth multiplier.
// Holds the control FSM state encoding and the default operand width.
package booth_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/booth_step.sv
// One radix-2 Booth iteration: conditional add/sub of M into A, then
// arithmetic shift right of {A,Q,Q(-1)}. Purely combinational, no backpressure.
module booth_step
  import booth_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH:0] a,
  input  logic [WIDTH:0] m,
  input  logic [WIDTH:0] q,
  input  logic           q_m1,
  output logic [WIDTH:0] a_next,
  output logic [WIDTH:0] q_next,
  output logic           q_m1_next
);

  logic [WIDTH:0] sum;

  always_comb begin
    sum = a;
    case ({q[0], q_m1})
      2'b01:   sum = a + m;
      2'b10:   sum = a - m;
      default: sum = a;
    endcase
    a_next    = {sum[WIDTH], sum[WIDTH:1]};
    q_next    = {sum[0], q[WIDTH:1]};
    q_m1_next = q[0];
  end

endmodule

// File: rtl/booth_seq_mult.sv
// Sequential Booth multiplier, signed or unsigned; done fires WIDTH+1 edges after start is taken.
// Start is only honoured in IDLE; requests while busy are dropped, not queued.
module booth_seq_mult
  import booth_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 signed_mode,
  input  logic [WIDTH-1:0]     M,
  input  logic [WIDTH-1:0]     Q,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   result
);

  localparam int            CW   = $clog2(WIDTH + 2);
  localparam logic [CW-1:0] LAST = CW'(WIDTH);

  state_t         state;
  state_t         state_nxt;
  logic [WIDTH:0] a_reg;
  logic [WIDTH:0] m_reg;
  logic [WIDTH:0] q_reg;
  logic           q_m1_reg;
  logic [CW-1:0]  cnt;

  logic [WIDTH:0] a_step;
  logic [WIDTH:0] q_step;
  logic           q_m1_step;

  booth_step #(.WIDTH(WIDTH)) u_step (
    .a         (a_reg),
    .m         (m_reg),
    .q         (q_reg),
    .q_m1      (q_m1_reg),
    .a_next    (a_step),
    .q_next    (q_step),
    .q_m1_next (q_m1_step)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nxt = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (cnt == LAST) state_nxt = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Operands carry one extra bit so that -M of the most negative value still fits in A.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_reg    <= '0;
      m_reg    <= '0;
      q_reg    <= '0;
      q_m1_reg <= 1'b0;
      cnt      <= '0;
      result   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_reg    <= '0;
            q_m1_reg <= 1'b0;
            cnt      <= '0;
            m_reg    <= {signed_mode & M[WIDTH-1], M};
            q_reg    <= {signed_mode & Q[WIDTH-1], Q};
          end
        end
        RUN: begin
          a_reg    <= a_step;
          q_reg    <= q_step;
          q_m1_reg <= q_m1_step;
          cnt      <= cnt + CW'(1);
          if (cnt == LAST) begin
            result <= {a_step[WIDTH-2:0], q_step};
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_booth_seq_mult.sv
// Directed and randomized checks of booth_seq_mult at WIDTH=4 and WIDTH=16.
module tb_booth_seq_mult;

  logic clk = 1'b0;
  logic rst;

  logic        start4, sm4;
  logic [3:0]  m4, q4;
  logic        busy4, done4;
  logic [7:0]  res4;

  logic        start16, sm16;
  logic [15:0] m16, q16;
  logic        busy16, done16;
  logic [31:0] res16;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  booth_seq_mult #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .signed_mode(sm4),
    .M(m4), .Q(q4), .busy(busy4), .done(done4), .result(res4)
  );

  booth_seq_mult #(.WIDTH(16)) dut16 (
    .clk(clk), .rst(rst), .start(start16), .signed_mode(sm16),
    .M(m16), .Q(q16), .busy(busy16), .done(done16), .result(res16)
  );

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Issue one WIDTH=4 multiply; optionally scramble inputs every cycle while it runs.
  task automatic run4(input string tag, input logic sm, input logic [3:0] m, input logic [3:0] q,
                      input logic [7:0] exp, input bit scramble);
    int n;
    bit seen;
    n = 0;
    @(negedge clk);
    while (busy4 && n < 50) begin
      @(negedge clk);
      n++;
    end
    start4 = 1'b1; sm4 = sm; m4 = m; q4 = q;
    @(posedge clk); #1;
    start4 = 1'b0;
    seen = 1'b0;
    n = 0;
    for (int i = 1; i <= 20 && !seen; i++) begin
      if (scramble) begin
        m4 = 4'($urandom); q4 = 4'($urandom); sm4 = 1'($urandom); start4 = 1'($urandom);
      end
      @(posedge clk); #1;
      n = i;
      if (done4) seen = 1'b1;
    end
    start4 = 1'b0;
    chk({tag, " latency"}, 64'(n), 64'd5);
    chk({tag, " result"}, 64'(res4), 64'(exp));
  endtask

  task automatic run16(input logic sm, input logic [15:0] m, input logic [15:0] q,
                       input logic [31:0] exp);
    int n;
    bit seen;
    @(negedge clk);
    start16 = 1'b1; sm16 = sm; m16 = m; q16 = q;
    @(posedge clk); #1;
    start16 = 1'b0;
    m16 = ~m; q16 = ~q;
    seen = 1'b0;
    n = 0;
    for (int i = 1; i <= 30 && !seen; i++) begin
      @(posedge clk); #1;
      n = i;
      if (done16) seen = 1'b1;
    end
    chk("w16 latency", 64'(n), 64'd17);
    chk(sm ? "w16 signed" : "w16 unsigned", 64'(res16), 64'(exp));
    @(posedge clk); #1;
  endtask

  initial begin
    int dones, idles, bad_sp, bad_res;
    logic [15:0] a, b;
    logic signed [31:0] sp;
    logic [31:0] up;

    rst = 1'b1;
    start4 = 1'b0; sm4 = 1'b0; m4 = '0; q4 = '0;
    start16 = 1'b0; sm16 = 1'b0; m16 = '0; q16 = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset busy", 64'(busy4), 64'd0);
    chk("reset done", 64'(done4), 64'd0);
    chk("reset result", 64'(res4), 64'd0);
    chk("reset result w16", 64'(res16), 64'd0);
    rst = 1'b0;

    run4("s 3*7",   1'b1, 4'd3,  4'd7,  8'h15, 1'b0);
    run4("s 3*-7",  1'b1, 4'd3,  4'h9,  8'hEB, 1'b0);
    run4("s -3*-7", 1'b1, 4'hD,  4'h9,  8'h15, 1'b0);
    run4("s 5*6",   1'b1, 4'd5,  4'd6,  8'h1E, 1'b0);
    run4("s 5*-6",  1'b1, 4'd5,  4'hA,  8'hE2, 1'b0);
    run4("s -5*-6", 1'b1, 4'hB,  4'hA,  8'h1E, 1'b0);
    run4("s -8*-8", 1'b1, 4'h8,  4'h8,  8'h40, 1'b0);
    run4("s -8*7",  1'b1, 4'h8,  4'd7,  8'hC8, 1'b0);
    run4("u 15*15", 1'b0, 4'hF,  4'hF,  8'hE1, 1'b0);
    run4("u 8*0",   1'b0, 4'h8,  4'h0,  8'h00, 1'b0);
    run4("u 8*15",  1'b0, 4'h8,  4'hF,  8'h78, 1'b0);
    run4("scrambled 3*7", 1'b1, 4'd3, 4'd7, 8'h15, 1'b1);

    // Start held high from reset release: accept on first edge, then every 7 edges.
    @(negedge clk);
    rst = 1'b1; start4 = 1'b1; sm4 = 1'b1; m4 = 4'd3; q4 = 4'd7;
    @(posedge clk); #1;
    rst = 1'b0;
    dones = 0; idles = 0; bad_sp = 0; bad_res = 0;
    for (int i = 0; i < 28; i++) begin
      @(posedge clk); #1;
      if (done4) begin
        dones++;
        if (i % 7 != 5) bad_sp++;
        if (res4 !== 8'h15) bad_res++;
      end
      if (!busy4) begin
        idles++;
        if (i % 7 != 6) bad_sp++;
      end
    end
    start4 = 1'b0;
    chk("held done count", 64'(dones), 64'd4);
    chk("held idle count", 64'(idles), 64'd4);
    chk("held spacing", 64'(bad_sp), 64'd0);
    chk("held results", 64'(bad_res), 64'd0);

    // Reset landing on the second iteration edge aborts the multiply silently.
    @(posedge clk); #1;
    start4 = 1'b1; sm4 = 1'b1; m4 = 4'd3; q4 = 4'd7;
    @(posedge clk); #1;
    start4 = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    dones = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (done4) dones++;
    end
    chk("abort no done", 64'(dones), 64'd0);
    chk("abort result", 64'(res4), 64'd0);
    chk("abort busy", 64'(busy4), 64'd0);
    run4("after abort 5*-6", 1'b1, 4'd5, 4'hA, 8'hE2, 1'b0);

    // Width 16 randomized against a behavioural product.
    for (int k = 0; k < 1000; k++) begin
      a = 16'($urandom);
      b = 16'($urandom);
      if (k == 0) begin a = 16'h8000; b = 16'h8000; end
      if (k == 1) begin a = 16'hFFFF; b = 16'hFFFF; end
      if (k[0]) begin
        sp = $signed(a) * $signed(b);
        run16(1'b1, a, b, 32'(sp));
      end else begin
        up = {16'd0, a} * {16'd0, b};
        run16(1'b0, a, b, up);
      end
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/booth_seq_mult.md
BOOTH_SEQ_MULT -- requirements
Module: booth_seq_mult

Interface
REQ-001 SHALL have parameter WIDTH, default 8: operand width in bits; legal range 2..32.
REQ-002 SHALL have port clk, input, 1 bit: single clock, all state updates on rising edge.
REQ-003 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have port start, input, 1 bit: request a multiply; sampled only in IDLE.
REQ-005 SHALL have port signed_mode, input, 1 bit: 1 means operands are two's complement, 0 means unsigned; sampled with start.
REQ-006 SHALL have port M, input, WIDTH bits: multiplicand; sampled with start.
REQ-007 SHALL have port Q, input, WIDTH bits: multiplier; sampled with start.
REQ-008 SHALL have port busy, output, 1 bit: high in RUN and DONE.
REQ-009 SHALL have port done, output, 1 bit: single-cycle pulse; result valid.
REQ-010 SHALL have port result, output, 2*WIDTH bits: product, held until the next done.

Function
REQ-011 SHALL implement a Moore FSM with states IDLE, RUN and DONE.
REQ-012 SHALL transition IDLE->RUN on an edge where start=1, latching the extended operands and the mode.
REQ-013 SHALL extend M and Q to WIDTH+1 bits (sign-extend if signed_mode=1, zero-extend otherwise) and clear accumulator A (WIDTH+1 bits), the Q(-1) bit and the iteration counter at the same edge.
REQ-014 SHALL perform one radix-2 Booth iteration per RUN cycle, using the pair {Q0,Q(-1)} as follows:
  - 01: A := A+M
  - 10: A := A-M
  - 00/11: A unchanged
  - then arithmetic shift right of {A,Q,Q(-1)} by 1.
REQ-015 SHALL execute exactly WIDTH+1 iterations, independent of operand values and mode.
REQ-016 SHALL transition RUN->DONE on the edge performing iteration WIDTH+1, loading result with the low 2*WIDTH bits of {A,Q}.
REQ-017 SHALL assert done for exactly the one cycle spent in DONE, then return to IDLE unconditionally.
REQ-018 SHALL make latency fixed: done high in the (WIDTH+1)th cycle after the start-accepting edge; throughput one multiply per WIDTH+3 cycles.
REQ-019 SHALL ignore start in RUN and DONE, with no queuing and no effect on the in-flight operation.
REQ-020 SHALL ignore changes on M, Q and signed_mode after the start-accepting edge.
REQ-021 SHALL produce a correct result for every operand pair in both modes, including M = -2^(WIDTH-1) (A is WIDTH+1 bits wide, so it cannot overflow).
REQ-022 SHALL keep result stable from done until the next RUN->DONE edge.

Reset
REQ-023 SHALL, when rst=1 at an edge, force: state=IDLE, busy=0, done=0, result=0, A=0, counter=0, Q(-1)=0.
REQ-024 SHALL make rst take priority over start and abort any in-flight operation with no done pulse.
REQ-025 SHALL make start accepted at the first edge after rst deasserts.

Structure
REQ-026 SHALL place the FSM state encoding and the default WIDTH constant in shared package booth_pkg.
REQ-027 SHALL isolate one iteration (add/sub select plus arithmetic shift, purely combinational, parametrised on WIDTH) in sub-module booth_step.
REQ-028 SHALL size the iteration counter to $clog2(WIDTH+2) bits.

Verification (WIDTH=4 unless stated)
REQ-029 SHALL cover the signed table, each with done in cycle 5 after start:
  - 3*7 -> 0x15
  - 3*-7 -> 0xEB
  - -3*-7 -> 0x15
  - 5*6 -> 0x1E
  - 5*-6 -> 0xE2
  - -5*-6 -> 0x1E
REQ-030 SHALL cover corners:
  - signed -8*-8 -> 0x40
  - signed -8*7 -> 0xC8
  - unsigned 15*15 -> 0xE1
  - unsigned 8*0 -> 0x00
REQ-031 SHALL cover start held high continuously: multiplies accepted every 7 cycles, with exactly one done per accepted start and busy low only in IDLE.
REQ-032 SHALL cover M and Q changed every cycle during RUN after start with 3*7: result is still 0x15.
REQ-033 SHALL cover rst pulsed in iteration 2: no done, and result=0; a following start with 5*-6 yields 0xE2.
REQ-034 SHALL cover WIDTH=16 with 1000 random signed and unsigned pairs against a reference product: all match, done at cycle 17.
